interrupt_priority_unit: RTL and testbench
==========================================

# interrupt_priority_unit

- Clocked IRR / priority-resolver / ISR stage of the 8259 PIC, directly upstream of Control_logic.
- Synchronises and latches the eight IR request lines, then applies the OCW1 mask.
- Resolves priority in fixed or rotating order, and drives `int_req` plus the IRR, ISR and priority indices that Control_logic consumes.
- Executes ISR set on the first INTA, and ISR clear on EOI or AEOI, as strobed by Control_logic.

## Interface
- `EDGE_SYNC`, 2, number of synchroniser flops on each `ir` line (≥2).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ir`  in  8  raw interrupt request lines, asynchronous to `clk`.
- `ltim`  in  1  ICW1_LTIM: 1 = level-triggered, 0 = edge-triggered.
- `imr`  in  8  interrupt mask (OCW1); 1 = masked.
- `aeoi`  in  1  ICW4_AEOI mode.
- `auto_rotate`  in  1  rotate priority on EOI/AEOI.
- `set_isr`  in  1  one-cycle strobe at the first INTA (begin_to_set_ISR).
- `second_inta`  in  1  one-cycle strobe at the end of the second INTA (vecFlag).
- `eoi`  in  1  one-cycle EOI command strobe.
- `specific_eoi`  in  1  1 = clear `eoi_level`; 0 = non-specific EOI.
- `eoi_level`  in  3  target level for specific EOI (reset_by_EOI).
- `int_req`  out  1  registered INT request to Control_logic.
- `irr`  out  8  interrupt request register.
- `isr`  out  8  in-service register.
- `highest_irr`  out  3  highest-priority unmasked pending level (vector low bits).
- `highest_isr`  out  3  highest-priority in-service level.

## Operation
- **Reset values:** `irr`=0, `isr`=0, `int_req`=0, `highest_irr`=7, `highest_isr`=0, internal `lowest_prio`=7 (IR0 highest).
- **Input sync:** each `ir` bit passes through `EDGE_SYNC` flops, giving `irs`, plus one history flop `irs_d`.
- **Edge mode (`ltim`=0):**
  - `irr[i]` sets when `irs[i]` & ~`irs_d[i]`.
  - `irr[i]` clears on acknowledge, or when `irs[i]`=0 (request withdrawn).
- **Level mode (`ltim`=1):**
  - `irr[i]` <= `irs[i]` every cycle.
  - The bit being acknowledged is forced to 0 for that cycle.
- **Priority order:** starts at (`lowest_prio`+1) mod 8 and wraps to `lowest_prio`.
- **Request resolution:**
  - cand = `irr` & ~`imr`.
  - `highest_irr` = first cand bit in priority order; 7 when cand=0 (spurious IR7).
- **`highest_isr`:** first `isr` bit in priority order; 0 when `isr`=0.
- **`int_req` (fully nested):** registered, =1 iff cand≠0 and the highest cand level is strictly higher priority than every set `isr` bit.
- **`set_isr` with cand≠0:** `isr[highest_irr]`<=1 and `irr[highest_irr]`<=0; level latched as `ack_level`.
- **`set_isr` with cand=0:** no ISR change; `ack_level`=7.
- **Specific EOI (`eoi` & `specific_eoi`):** clears `isr[eoi_level]`, whether or not that bit is set.
- **Non-specific EOI:** clears the bit at `highest_isr`; no-op when `isr`=0.
- **Rotation on EOI:** if `auto_rotate`=1, `lowest_prio` <= the cleared level. A no-op EOI does not rotate.
- **AEOI:**
  - When `aeoi`=1 and `second_inta` is strobed, clear `isr[ack_level]`.
  - Rotate as for EOI if `auto_rotate`=1.
  - `eoi` strobes are still honoured in AEOI mode.
- **Mask changes:** `imr` changes affect `highest_irr` combinationally and `int_req` on the next edge; `irr` is never altered by `imr`.

## Timing
- **Request latency:** `ir` rising → `irr` bit set at the (`EDGE_SYNC`+1)th rising edge → `int_req`=1 at the (`EDGE_SYNC`+2)th edge (4 with default).
- **`set_isr` edge:** `isr`/`irr` update on the edge that samples the strobe; `int_req` re-evaluates one edge later.
- **`eoi` and `set_isr` in the same cycle:**
  - EOI is evaluated against the pre-update `isr`, then the set is applied.
  - If both touch the same bit, the set wins.
- **`second_inta` with AEOI and `eoi` in the same cycle:** both clears apply. Rotation uses the AEOI level.
- **Reset mid-service:** `reset` sampled high forces all reset values on that edge, regardless of other strobes.
- **Synchroniser after reset:** contents are cleared, so `ir` already high at reset release counts as a rising edge in edge mode.

## Test plan
1. **Edge request latency:** reset, `ltim`=0, `imr`=0, `ir`=0x60 → `irr`=0x60 after 3 edges; `int_req`=1 at edge 4; `highest_irr`=5.
2. **Acknowledge and nesting:** from 1, strobe `set_isr` → `isr`=0x20, `irr`=0x40; `int_req`=0 next edge (IR6 blocked by in-service IR5).
3. **Non-specific EOI:** from 2, non-specific `eoi` → `isr`=0x00; `int_req`=1 next edge; `highest_irr`=6.
4. **Masking and level mode:**
   - `imr`=0x40 with `irr`=0x40 → `int_req`=0 and `irr` stays 0x40.
   - `ltim`=1 with `ir`[6] held high, ack, then clear the mask → `irr`[6] reasserts the cycle after the ack.
5. **Rotation:**
   - In service IR2 with `auto_rotate`=1, specific EOI level 2 → `lowest_prio`=2.
   - Then `ir`=0x09 → `highest_irr`=3 (IR3 beats IR0).
6. **AEOI and reset:**
   - `aeoi`=1, ack IR1, then `second_inta` → `isr`=0x00 on that edge.
   - Separately, `reset` pulse with `isr`=0x82 and `irr`=0x11 → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/interrupt_priority_unit.sv
// interrupt_priority_unit: 8259 IRR / priority resolver / ISR stage.
// Syncs IR lines, latches requests, resolves fixed/rotating priority,
// and maintains the in-service register for Control_logic.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ir[7:0]            raw async request lines
//   ltim               1 = level-triggered, 0 = edge-triggered
//   imr[7:0]           interrupt mask, 1 = masked
//   aeoi, auto_rotate  AEOI mode, rotate-on-EOI mode
//   set_isr            strobe at first INTA
//   second_inta        strobe at end of second INTA
//   eoi, specific_eoi  EOI strobe and specific/non-specific select
//   eoi_level[2:0]     target level for specific EOI
//   int_req            registered INT request
//   irr, isr           request and in-service registers
//   highest_irr        highest unmasked pending level (7 if none)
//   highest_isr        highest in-service level (0 if none)
module interrupt_priority_unit #(
    parameter int EDGE_SYNC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic [7:0] imr,
    input  logic       aeoi,
    input  logic       auto_rotate,
    input  logic       set_isr,
    input  logic       second_inta,
    input  logic       eoi,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    output logic       int_req,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] highest_irr,
    output logic [2:0] highest_isr
);

    logic [7:0] sync_q [EDGE_SYNC];
    logic [7:0] irs;
    logic [7:0] irs_d;
    logic [2:0] lowest_prio;
    logic [2:0] ack_level;

    logic [7:0] cand;
    logic       cand_any;
    logic [2:0] cand_lvl;
    logic       isr_any;
    logic [2:0] isr_lvl;
    logic       int_req_nxt;
    logic [7:0] ack_mask;
    logic [7:0] irr_nxt;
    logic [7:0] isr_nxt;
    logic       eoi_hit;
    logic [2:0] eoi_lvl;
    logic       aeoi_hit;
    logic [2:0] lowest_nxt;
    logic [2:0] ack_nxt;

    assign irs = sync_q[EDGE_SYNC-1];

    // Scan from lowest priority up to highest so the last hit wins;
    // returns {found, level}.
    function automatic logic [3:0] find_first(
        input logic [7:0] vec,
        input logic [2:0] lowest
    );
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            lvl = lowest + 3'(k);
            if (vec[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    // 0 = highest priority under the current rotation.
    function automatic logic [2:0] rank(
        input logic [2:0] lvl,
        input logic [2:0] lowest
    );
        return lvl - lowest - 3'd1;
    endfunction

    always_comb begin
        cand = irr & ~imr;
        {cand_any, cand_lvl} = find_first(cand, lowest_prio);
        {isr_any, isr_lvl}   = find_first(isr, lowest_prio);

        highest_irr = cand_any ? cand_lvl : 3'd7;
        highest_isr = isr_any ? isr_lvl : 3'd0;

        // highest_isr is the top set ISR bit, so beating it beats all.
        int_req_nxt = cand_any &&
            (!isr_any ||
             (rank(cand_lvl, lowest_prio) < rank(isr_lvl, lowest_prio)));

        ack_mask = 8'b0;
        if (set_isr && cand_any) ack_mask = 8'b1 << cand_lvl;

        if (ltim)
            irr_nxt = irs & ~ack_mask;
        else
            irr_nxt = (irr | (irs & ~irs_d)) & irs & ~ack_mask;

        eoi_hit  = eoi && (specific_eoi || isr_any);
        eoi_lvl  = specific_eoi ? eoi_level : isr_lvl;
        aeoi_hit = aeoi && second_inta;

        // Clears see the pre-update ISR; the set is applied last.
        isr_nxt = isr;
        if (eoi_hit) isr_nxt[eoi_lvl] = 1'b0;
        if (aeoi_hit) isr_nxt[ack_level] = 1'b0;
        isr_nxt = isr_nxt | ack_mask;

        lowest_nxt = lowest_prio;
        if (auto_rotate) begin
            if (aeoi_hit)
                lowest_nxt = ack_level;
            else if (eoi_hit)
                lowest_nxt = eoi_lvl;
        end

        ack_nxt = ack_level;
        if (set_isr) ack_nxt = cand_any ? cand_lvl : 3'd7;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < EDGE_SYNC; i++) sync_q[i] <= 8'b0;
            irs_d       <= 8'b0;
            irr         <= 8'b0;
            isr         <= 8'b0;
            int_req     <= 1'b0;
            lowest_prio <= 3'd7;
            ack_level   <= 3'd7;
        end else begin
            sync_q[0] <= ir;
            for (int i = 1; i < EDGE_SYNC; i++) sync_q[i] <= sync_q[i-1];
            irs_d       <= irs;
            irr         <= irr_nxt;
            isr         <= isr_nxt;
            int_req     <= int_req_nxt;
            lowest_prio <= lowest_nxt;
            ack_level   <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_interrupt_priority_unit.sv
// tb_interrupt_priority_unit: directed scenarios plus randomized
// run against a priority-order reference model.
module tb_interrupt_priority_unit;

    localparam int ES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir;
    logic       ltim;
    logic [7:0] imr;
    logic       aeoi;
    logic       auto_rotate;
    logic       set_isr;
    logic       second_inta;
    logic       eoi;
    logic       specific_eoi;
    logic [2:0] eoi_level;
    logic       int_req;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] highest_irr;
    logic [2:0] highest_isr;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0] m_irr, m_isr;
    logic       m_int;
    int         m_lowest, m_ack;
    logic [7:0] hist[$];

    interrupt_priority_unit #(.EDGE_SYNC(ES)) dut (
        .clk(clk), .reset(reset), .ir(ir), .ltim(ltim), .imr(imr),
        .aeoi(aeoi), .auto_rotate(auto_rotate), .set_isr(set_isr),
        .second_inta(second_inta), .eoi(eoi),
        .specific_eoi(specific_eoi), .eoi_level(eoi_level),
        .int_req(int_req), .irr(irr), .isr(isr),
        .highest_irr(highest_irr), .highest_isr(highest_isr)
    );

    always #5 clk = ~clk;

    // First set level walking from lowest+1 around to lowest.
    function automatic int first_lvl(logic [7:0] v, int lowest, int dflt);
        for (int k = 1; k <= 8; k++)
            if (v[(lowest + k) % 8]) return (lowest + k) % 8;
        return dflt;
    endfunction

    function automatic int rank(int lvl, int lowest);
        return (lvl - lowest + 7) % 8;
    endfunction

    task automatic model_edge();
        logic [7:0] cand, nirr, nisr, s, sd;
        int h, hs, rot;
        logic nint, acked;
        if (reset) begin
            m_irr = 0; m_isr = 0; m_int = 0;
            m_lowest = 7; m_ack = 7;
            hist = {};
            repeat (ES + 1) hist.push_back(8'h00);
        end else begin
            cand = m_irr & ~imr;
            h  = first_lvl(cand, m_lowest, 7);
            hs = first_lvl(m_isr, m_lowest, -1);
            nint = (cand != 0);
            for (int i = 0; i < 8; i++)
                if (m_isr[i] && rank(i, m_lowest) <= rank(h, m_lowest))
                    nint = 0;
            s  = hist[ES-1];
            sd = hist[ES];
            for (int i = 0; i < 8; i++)
                nirr[i] = ltim ? s[i] : (s[i] && (m_irr[i] || !sd[i]));
            acked = set_isr && (cand != 0);
            if (acked) nirr[h] = 1'b0;
            nisr = m_isr;
            rot = -1;
            if (eoi) begin
                if (specific_eoi) begin
                    nisr[eoi_level] = 1'b0; rot = int'(eoi_level);
                end else if (hs >= 0) begin
                    nisr[hs] = 1'b0; rot = hs;
                end
            end
            if (aeoi && second_inta) begin
                nisr[m_ack] = 1'b0; rot = m_ack;
            end
            if (acked) nisr[h] = 1'b1;
            if (auto_rotate && rot >= 0) m_lowest = rot;
            if (set_isr) m_ack = acked ? h : 7;
            m_irr = nirr; m_isr = nisr; m_int = nint;
            hist.push_front(ir);
            void'(hist.pop_back());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        set_isr = 0; second_inta = 0; eoi = 0;
        specific_eoi = 0; eoi_level = 0;
    endtask

    task automatic do_reset();
        reset = 1; step(); reset = 0;
    endtask

    task automatic test_reset();
        ir = 0; ltim = 0; imr = 0; aeoi = 0; auto_rotate = 0;
        idle();
        do_reset();
        tests++; if (irr !== 8'h00) begin fails++; $display("FAIL rst_irr got %h want 00", irr); end
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL rst_isr got %h want 00", isr); end
        tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL rst_int got %b want 0", int_req); end
        tests++; if (highest_irr !== 3'd7) begin fails++; $display("FAIL rst_hirr got %0d want 7", highest_irr); end
        tests++; if (highest_isr !== 3'd0) begin fails++; $display("FAIL rst_hisr got %0d want 0", highest_isr); end
    endtask

    task automatic test_edge_latency();
        ir = 8'h60;
        step(); step();
        tests++; if (irr !== 8'h00) begin fails++; $display("FAIL lat_irr_early got %h want 00", irr); end
        step();
        tests++; if (irr !== 8'h60) begin fails++; $display("FAIL lat_irr got %h want 60", irr); end
        tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL lat_int_early got %b want 0", int_req); end
        step();
        tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL lat_int got %b want 1", int_req); end
        tests++; if (highest_irr !== 3'd5) begin fails++; $display("FAIL lat_hirr got %0d want 5", highest_irr); end
    endtask

    task automatic test_ack_nesting();
        set_isr = 1; step(); set_isr = 0;
        tests++; if (isr !== 8'h20) begin fails++; $display("FAIL ack_isr got %h want 20", isr); end
        tests++; if (irr !== 8'h40) begin fails++; $display("FAIL ack_irr got %h want 40", irr); end
        tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL ack_int_same got %b want 1", int_req); end
        step();
        tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL ack_int_nest got %b want 0", int_req); end
        tests++; if (highest_isr !== 3'd5) begin fails++; $display("FAIL ack_hisr got %0d want 5", highest_isr); end
    endtask

    task automatic test_eoi();
        eoi = 1; specific_eoi = 0; step(); idle();
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL eoi_isr got %h want 00", isr); end
        step();
        tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL eoi_int got %b want 1", int_req); end
        tests++; if (highest_irr !== 3'd6) begin fails++; $display("FAIL eoi_hirr got %0d want 6", highest_irr); end
    endtask

    task automatic test_mask_level();
        imr = 8'h40; #1;
        tests++; if (highest_irr !== 3'd7) begin fails++; $display("FAIL mask_hirr got %0d want 7", highest_irr); end
        step();
        tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL mask_int got %b want 0", int_req); end
        tests++; if (irr !== 8'h40) begin fails++; $display("FAIL mask_irr got %h want 40", irr); end
        ir = 8'h40; ltim = 1; imr = 8'h00;
        step(); step(); step(); step();
        tests++; if (irr !== 8'h40) begin fails++; $display("FAIL lvl_irr got %h want 40", irr); end
        tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL lvl_int got %b want 1", int_req); end
        set_isr = 1; step(); set_isr = 0;
        tests++; if (irr !== 8'h00) begin fails++; $display("FAIL lvl_ack_irr got %h want 00", irr); end
        tests++; if (isr !== 8'h40) begin fails++; $display("FAIL lvl_ack_isr got %h want 40", isr); end
        step();
        tests++; if (irr !== 8'h40) begin fails++; $display("FAIL lvl_reassert got %h want 40", irr); end
        eoi = 1; step(); idle();
        ltim = 0;
    endtask

    task automatic test_rotation();
        ir = 8'h04; do_reset();
        auto_rotate = 1;
        step(); step(); step(); step();
        tests++; if (highest_irr !== 3'd2) begin fails++; $display("FAIL rot_hirr0 got %0d want 2", highest_irr); end
        set_isr = 1; step(); set_isr = 0;
        tests++; if (isr !== 8'h04) begin fails++; $display("FAIL rot_isr got %h want 04", isr); end
        eoi = 1; specific_eoi = 1; eoi_level = 3'd2; step(); idle();
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL rot_eoi got %h want 00", isr); end
        ir = 8'h09;
        step(); step(); step();
        tests++; if (irr !== 8'h09) begin fails++; $display("FAIL rot_irr got %h want 09", irr); end
        tests++; if (highest_irr !== 3'd3) begin fails++; $display("FAIL rot_hirr got %0d want 3", highest_irr); end
        step();
        tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL rot_int got %b want 1", int_req); end
        auto_rotate = 0;
    endtask

    task automatic test_aeoi();
        ir = 8'h02; aeoi = 1; do_reset();
        step(); step(); step(); step();
        tests++; if (highest_irr !== 3'd1) begin fails++; $display("FAIL aeoi_hirr got %0d want 1", highest_irr); end
        set_isr = 1; step(); set_isr = 0;
        tests++; if (isr !== 8'h02) begin fails++; $display("FAIL aeoi_ack got %h want 02", isr); end
        second_inta = 1; step(); second_inta = 0;
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL aeoi_clr got %h want 00", isr); end
        aeoi = 0;
    endtask

    task automatic test_reset_mid_service();
        ir = 8'h80; do_reset();
        step(); step(); step(); step();
        set_isr = 1; step(); set_isr = 0;
        ir = 8'h82;
        step(); step(); step(); step();
        tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL mid_nest_int got %b want 1", int_req); end
        set_isr = 1; step(); set_isr = 0;
        ir = 8'h93;
        step(); step(); step();
        tests++; if (isr !== 8'h82) begin fails++; $display("FAIL mid_isr got %h want 82", isr); end
        tests++; if (irr !== 8'h11) begin fails++; $display("FAIL mid_irr got %h want 11", irr); end
        reset = 1; set_isr = 1; eoi = 1; step(); reset = 0; idle();
        tests++; if (isr !== 8'h00) begin fails++; $display("FAIL mid_rst_isr got %h want 00", isr); end
        tests++; if (irr !== 8'h00) begin fails++; $display("FAIL mid_rst_irr got %h want 00", irr); end
        tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL mid_rst_int got %b want 0", int_req); end
        tests++; if (highest_irr !== 3'd7) begin fails++; $display("FAIL mid_rst_hirr got %0d want 7", highest_irr); end
        tests++; if (highest_isr !== 3'd0) begin fails++; $display("FAIL mid_rst_hisr got %0d want 0", highest_isr); end
        step(); step(); step();
        tests++; if (irr !== 8'h93) begin fails++; $display("FAIL post_rst_edge got %h want 93", irr); end
    endtask

    task automatic test_back_to_back();
        ir = 8'h01; do_reset();
        step(); step(); step(); step();
        set_isr = 1; step(); set_isr = 0;
        ir = 8'h00;
        step(); step(); step();
        ir = 8'h01;
        step(); step(); step(); step();
        tests++; if (irr !== 8'h01) begin fails++; $display("FAIL b2b_irr got %h want 01", irr); end
        tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL b2b_blocked got %b want 0", int_req); end
        set_isr = 1; eoi = 1; specific_eoi = 0; step(); idle();
        tests++; if (isr !== 8'h01) begin fails++; $display("FAIL b2b_isr got %h want 01", isr); end
        tests++; if (irr !== 8'h00) begin fails++; $display("FAIL b2b_irr_clr got %h want 00", irr); end
    endtask

    task automatic test_random();
        int ex_hirr, ex_hisr;
        ir = 0; imr = 0; ltim = 0; aeoi = 0; auto_rotate = 0;
        idle(); do_reset();
        for (int n = 0; n < 2000; n++) begin
            reset        = ($urandom_range(0, 299) == 0);
            set_isr      = ($urandom_range(0, 5) == 0);
            eoi          = ($urandom_range(0, 7) == 0);
            second_inta  = ($urandom_range(0, 7) == 0);
            specific_eoi = ($urandom_range(0, 1) == 1);
            eoi_level    = 3'($urandom_range(0, 7));
            if (n % 200 == 0) aeoi = ($urandom_range(0, 1) == 1);
            if (n % 100 == 0) auto_rotate = ($urandom_range(0, 1) == 1);
            if (n % 300 == 0) ltim = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                ir = ir ^ (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0)
                imr = 8'($urandom) & 8'($urandom);
            step();
            ex_hirr = first_lvl(m_irr & ~imr, m_lowest, 7);
            ex_hisr = first_lvl(m_isr, m_lowest, 0);
            tests++; if (irr !== m_irr) begin fails++; $display("FAIL rnd_irr cyc %0d got %h want %h", n, irr, m_irr); end
            tests++; if (isr !== m_isr) begin fails++; $display("FAIL rnd_isr cyc %0d got %h want %h", n, isr, m_isr); end
            tests++; if (int_req !== m_int) begin fails++; $display("FAIL rnd_int cyc %0d got %b want %b", n, int_req, m_int); end
            tests++; if (highest_irr !== 3'(ex_hirr)) begin fails++; $display("FAIL rnd_hirr cyc %0d got %0d want %0d", n, highest_irr, ex_hirr); end
            tests++; if (highest_isr !== 3'(ex_hisr)) begin fails++; $display("FAIL rnd_hisr cyc %0d got %0d want %0d", n, highest_isr, ex_hisr); end
        end
        reset = 0; idle();
    endtask

    initial begin
        reset = 1;
        test_reset();
        test_edge_latency();
        test_ack_nesting();
        test_eoi();
        test_mask_level();
        test_rotation();
        test_aeoi();
        test_reset_mid_service();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
